// File: rtl/isq_entry_ctrl.sv
// Issue-queue entry bookkeeping: free-slot pick, dual allocation,
// issue clear, branch hold/resolve, flush and occupancy tracking.
module isq_entry_ctrl #(
  parameter int ISQ_DEPTH        = 64,
  parameter int ISQ_IDX_BITS_NUM = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  alloc_req,
  input  logic [1:0]                  alloc_br,
  output logic [1:0]                  alloc_gnt,
  output logic [ISQ_IDX_BITS_NUM-1:0] alloc_idx0,
  output logic [ISQ_IDX_BITS_NUM-1:0] alloc_idx1,
  input  logic [ISQ_DEPTH-1:0]        iss_clr,
  input  logic                        br_done,
  input  logic [ISQ_IDX_BITS_NUM-1:0] br_idx,
  input  logic                        flush,
  output logic [ISQ_DEPTH-1:0]        inst_vld,
  output logic [ISQ_DEPTH-1:0]        inst_wat,
  output logic [ISQ_IDX_BITS_NUM:0]   isq_cnt,
  output logic                        isq_full
);

  localparam int CW = ISQ_IDX_BITS_NUM + 1;

  logic [ISQ_DEPTH-1:0]        br_q;
  logic [ISQ_DEPTH-1:0]        vld_n;
  logic [ISQ_DEPTH-1:0]        wat_n;
  logic [ISQ_DEPTH-1:0]        br_n;
  logic [ISQ_DEPTH-1:0]        iss_hit;
  logic [ISQ_IDX_BITS_NUM-1:0] free0;
  logic [ISQ_IDX_BITS_NUM-1:0] free1;
  logic                        has0;
  logic                        has1;
  logic                        res_hit;
  logic [CW-1:0]               cnt_n;
  logic                        full_n;

  always_comb begin
    free0 = '0;
    free1 = '0;
    has0  = 1'b0;
    has1  = 1'b0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      if (!inst_vld[i]) begin
        if (!has0) begin
          free0 = ISQ_IDX_BITS_NUM'(i);
          has0  = 1'b1;
        end else if (!has1) begin
          free1 = ISQ_IDX_BITS_NUM'(i);
          has1  = 1'b1;
        end
      end
    end
  end

  // slot1 only ever rides along with slot0
  assign alloc_gnt[0] = rst_n & ~flush & alloc_req[0] & has0;
  assign alloc_gnt[1] = alloc_gnt[0] & alloc_req[1] & has1;
  assign alloc_idx0   = free0;
  assign alloc_idx1   = free1;

  assign iss_hit = iss_clr & inst_vld & inst_wat;
  assign res_hit = br_done & inst_vld[br_idx]
                 & br_q[br_idx] & ~inst_wat[br_idx];

  always_comb begin
    vld_n = inst_vld & ~(iss_hit & ~br_q);
    wat_n = inst_wat & ~iss_hit;
    br_n  = br_q;
    if (res_hit) begin
      vld_n[br_idx] = 1'b0;
      br_n[br_idx]  = 1'b0;
    end
    if (alloc_gnt[0]) begin
      vld_n[free0] = 1'b1;
      wat_n[free0] = 1'b1;
      br_n[free0]  = alloc_br[0];
    end
    if (alloc_gnt[1]) begin
      vld_n[free1] = 1'b1;
      wat_n[free1] = 1'b1;
      br_n[free1]  = alloc_br[1];
    end
    if (flush) begin
      vld_n = '0;
      wat_n = '0;
      br_n  = '0;
    end
    cnt_n = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      cnt_n = cnt_n + CW'(vld_n[i]);
    end
    full_n = cnt_n > CW'(ISQ_DEPTH - 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_vld <= '0;
      inst_wat <= '0;
      br_q     <= '0;
      isq_cnt  <= '0;
      isq_full <= 1'b0;
    end else begin
      inst_vld <= vld_n;
      inst_wat <= wat_n;
      br_q     <= br_n;
      isq_cnt  <= cnt_n;
      isq_full <= full_n;
    end
  end

endmodule

// File: tb/tb_isq_entry_ctrl.sv
// Randomized bench for isq_entry_ctrl against a per-entry
// lifecycle model, plus directed literal scenarios.
module tb_isq_entry_ctrl;

  localparam int D = 64;
  localparam int B = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   alloc_req;
  logic [1:0]   alloc_br;
  logic [1:0]   alloc_gnt;
  logic [B-1:0] alloc_idx0;
  logic [B-1:0] alloc_idx1;
  logic [D-1:0] iss_clr;
  logic         br_done;
  logic [B-1:0] br_idx;
  logic         flush;
  logic [D-1:0] inst_vld;
  logic [D-1:0] inst_wat;
  logic [B:0]   isq_cnt;
  logic         isq_full;

  isq_entry_ctrl #(.ISQ_DEPTH(D), .ISQ_IDX_BITS_NUM(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_br(alloc_br),
    .alloc_gnt(alloc_gnt),
    .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1),
    .iss_clr(iss_clr), .br_done(br_done), .br_idx(br_idx),
    .flush(flush), .inst_vld(inst_vld), .inst_wat(inst_wat),
    .isq_cnt(isq_cnt), .isq_full(isq_full)
  );

  always #5 clk = ~clk;

  // entry lifecycle: 0 free, 1 waiting, 2 waiting branch, 3 issued branch
  int st[D];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nth_free(int n);
    int k = 0;
    for (int i = 0; i < D; i++)
      if (st[i] == 0) begin
        if (k == n) return i;
        k++;
      end
    return -1;
  endfunction

  function automatic logic [1:0] m_gnt();
    logic ok;
    ok = (rst_n === 1'b1) && !flush && alloc_req[0];
    m_gnt[0] = ok && nth_free(0) >= 0;
    m_gnt[1] = ok && alloc_req[1] && nth_free(1) >= 0;
  endfunction

  function automatic logic [D-1:0] m_vld();
    for (int i = 0; i < D; i++) m_vld[i] = st[i] != 0;
  endfunction

  function automatic logic [D-1:0] m_wat();
    for (int i = 0; i < D; i++) m_wat[i] = st[i] == 1 || st[i] == 2;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < D; i++) if (st[i] != 0) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) st[i] = 0;
    end else begin
      int nst[D];
      logic [1:0] g;
      int f0, f1;
      g  = m_gnt();
      f0 = nth_free(0);
      f1 = nth_free(1);
      nst = st;
      for (int i = 0; i < D; i++)
        if (iss_clr[i]) begin
          if (st[i] == 1) nst[i] = 0;
          if (st[i] == 2) nst[i] = 3;
        end
      if (br_done && st[br_idx] == 3) nst[br_idx] = 0;
      if (g[0]) nst[f0] = alloc_br[0] ? 2 : 1;
      if (g[1]) nst[f1] = alloc_br[1] ? 2 : 1;
      if (flush) for (int i = 0; i < D; i++) nst[i] = 0;
      st = nst;
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    int c;
    g = m_gnt();
    c = m_cnt();
    chk("vld", inst_vld, m_vld());
    chk("wat", inst_wat, m_wat());
    chk("cnt", 64'(isq_cnt), 64'(c));
    chk("full", 64'(isq_full), 64'((D - c) < 2));
    chk("gnt", 64'(alloc_gnt), 64'(g));
    if (g[0]) chk("idx0", 64'(alloc_idx0), 64'(nth_free(0)));
    if (g[1]) chk("idx1", 64'(alloc_idx1), 64'(nth_free(1)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 2'b00;
    alloc_br  = 2'b00;
    iss_clr   = '0;
    br_done   = 1'b0;
    br_idx    = '0;
    flush     = 1'b0;
  endtask

  function automatic logic [B-1:0] pick_br();
    int q[$];
    for (int i = 0; i < D; i++) if (st[i] == 3 || st[i] == 2) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      return B'(q[$urandom_range(0, q.size() - 1)]);
    return B'($urandom_range(0, D - 1));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    alloc_req = 2'b11;
    step();
    chk("rst_gnt", 64'(alloc_gnt), 64'd0);
    chk("rst_vld", inst_vld, 64'd0);
    chk("rst_cnt", 64'(isq_cnt), 64'd0);
    chk("rst_full", 64'(isq_full), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("e_gnt", 64'(alloc_gnt), 64'h3);
    chk("e_idx0", 64'(alloc_idx0), 64'd0);
    chk("e_idx1", 64'(alloc_idx1), 64'd1);
    step();
    idle();
    chk("e_vld", inst_vld, 64'h3);
    chk("e_wat", inst_wat, 64'h3);
    chk("e_cnt", 64'(isq_cnt), 64'd2);

    iss_clr = 64'h1;
    step();
    idle();
    chk("nb_vld", inst_vld, 64'h2);
    chk("nb_cnt", 64'(isq_cnt), 64'd1);
    alloc_req = 2'b01;
    #1;
    chk("nb_idx0", 64'(alloc_idx0), 64'd0);
    step();
    alloc_req = 2'b11;
    step();
    alloc_req = 2'b01;
    step();
    alloc_br = 2'b01;
    #1;
    chk("br_idx0", 64'(alloc_idx0), 64'd5);
    step();
    idle();
    br_done = 1'b1;
    br_idx  = 6'd5;
    step();
    idle();
    chk("early_vld", inst_vld, 64'h3f);
    chk("early_wat", inst_wat, 64'h3f);
    iss_clr = 64'h20;
    step();
    idle();
    chk("hold_vld", inst_vld, 64'h3f);
    chk("hold_wat", inst_wat, 64'h1f);
    br_done = 1'b1;
    br_idx  = 6'd5;
    step();
    idle();
    chk("res_vld", inst_vld, 64'h1f);
    chk("res_cnt", 64'(isq_cnt), 64'd5);

    flush = 1'b1;
    step();
    idle();
    alloc_req = 2'b11;
    repeat (31) step();
    alloc_req = 2'b01;
    step();
    alloc_req = 2'b11;
    #1;
    chk("nf_gnt", 64'(alloc_gnt), 64'h1);
    chk("nf_idx0", 64'(alloc_idx0), 64'd63);
    step();
    idle();
    chk("nf_cnt", 64'(isq_cnt), 64'd64);
    chk("nf_full", 64'(isq_full), 64'd1);

    iss_clr = 64'h1;
    step();
    idle();
    flush     = 1'b1;
    alloc_req = 2'b11;
    iss_clr   = 64'h6;
    br_done   = 1'b1;
    br_idx    = 6'd3;
    #1;
    chk("fl_gnt", 64'(alloc_gnt), 64'h0);
    step();
    idle();
    chk("fl_vld", inst_vld, 64'h0);
    chk("fl_wat", inst_wat, 64'h0);
    chk("fl_cnt", 64'(isq_cnt), 64'd0);
    chk("fl_full", 64'(isq_full), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      alloc_req = 2'($urandom);
      alloc_br  = 2'($urandom);
      iss_clr   = {$urandom, $urandom} & {$urandom, $urandom};
      if (c % 400 < 200) iss_clr = iss_clr & {$urandom, $urandom};
      br_done   = 1'($urandom);
      br_idx    = pick_br();
      flush     = $urandom_range(0, 149) == 0;
      if (c == 1500) begin
        alloc_req = 2'b11;
        flush     = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt", 64'(alloc_gnt), 64'h0);
        chk("mr_vld", inst_vld, 64'h0);
        chk("mr_cnt", 64'(isq_cnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;
      end
      step();
    end
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
